fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Sequencer for the instruction-fetch stage.
- Owns the program counter.
- Issues requests to a variable-latency instruction memory using a req/ready handshake.
- Delivers fetched instructions, each with its PC+4, to the IF/ID boundary under a valid/stall handshake.
- Handles branch/jump redirects, including redirects that arrive while a memory access is in flight.
- Sits between the hazard/branch logic in ID/EX and the instruction memory, replacing the free-running PC.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
PC_STEP, 4, sequential PC increment in bytes.
HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetch (used only with FETCH_HALT_EN).

Ports:
clk  in  1  clock; all state changes on rising edge.
reset  in  1  asynchronous, active-low reset.
o_imem_req  out  1  memory request; held high until ready.
o_imem_addr  out  32  fetch address; stable while o_imem_req is high.
i_imem_ready  in  1  memory response valid this cycle; qualifies i_imem_instr.
i_imem_instr  in  32  fetched instruction.
i_stall  in  1  IF/ID cannot accept; hold outputs.
i_redirect  in  1  single-cycle pulse; flush and refetch from i_redirect_pc.
i_redirect_pc  in  32  redirect target, sampled when i_redirect=1.
o_valid  out  1  o_instr/o_next_pc are valid.
o_instr  out  32  instruction presented to IF/ID.
o_next_pc  out  32  fetch PC + PC_STEP for that instruction.
o_halted  out  1  fetch stopped on HALT_INSTR (tied 0 without the macro).

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC, state=BOOT.
  - o_imem_req=0, o_valid=0, o_instr=0, o_next_pc=0, skid buffer empty, o_halted=0.
- States: BOOT, FETCH, FULL, DRAIN, HALT.
- BOOT: req=0 for one cycle after reset release, then -> FETCH.
- FETCH:
  - o_imem_req=1, o_imem_addr=pc.
  - On i_imem_ready:
    - pc <= pc+PC_STEP (mod 2^32, wraps silently).
    - If the output slot is free (o_valid=0 or i_stall=0): load o_instr, o_next_pc=pc+PC_STEP, o_valid=1 next cycle; stay in FETCH.
    - Otherwise: write the data into the one-entry skid buffer -> FULL.
  - Best case: one instruction per cycle with zero-wait memory. Latency from ready to o_valid is one cycle.
- FULL:
  - o_imem_req=0.
  - When the output is consumed (o_valid=1 and i_stall=0): the skid buffer moves to the output next cycle -> FETCH.
- Consumption rule: an output is consumed on any cycle with o_valid=1 and i_stall=0. Otherwise o_valid, o_instr and o_next_pc hold unchanged.
- Redirect (highest priority, any state except BOOT):
  - Next cycle: o_valid=0, skid buffer cleared, pc <= i_redirect_pc.
  - If a request is outstanding without ready this cycle -> DRAIN.
  - Else -> FETCH, with the new request issued the cycle after the redirect.
  - A ready arriving in the same cycle as the redirect is discarded.
- DRAIN:
  - req stays high at the old address, since an access cannot be aborted.
  - On ready: discard the data -> FETCH at the redirect PC.
  - A second redirect during DRAIN overwrites the target PC and stays in DRAIN.
- Stall and redirect in the same cycle: the redirect wins; the output is flushed.
- Reset asserted mid-operation: immediate return to reset values. Any memory response in flight is ignored.

Optional Feature:
FETCH_HALT_EN
- Defined:
  - An instruction equal to HALT_INSTR is delivered to the output normally.
  - The block then enters HALT: no further requests, o_halted=1.
  - Only i_redirect (-> FETCH, o_halted=0) or reset leaves HALT.
  - A redirect arriving in the same cycle as the halt capture wins; HALT is not entered.
- Undefined: HALT state and compare logic are absent; o_halted is tied to 0; HALT_INSTR is fetched as an ordinary word.

Decomposition:
- Package fetch_ctrl_pkg:
  - state encoding (BOOT, FETCH, FULL, DRAIN, HALT, 3 bits);
  - default RESET_PC, PC_STEP and HALT_INSTR constants;
  - instruction/address width 32.
- Sub-module fetch_skid_buf: one-entry instr+next_pc register with write, read and clear controls. Instantiated once.

Test Plan:
- Zero-wait memory (ready tied 1), no stalls, RESET_PC=0 -> o_imem_addr 0,4,8,... each cycle; o_valid from the 3rd cycle after reset release; o_next_pc = 4,8,12.
- Memory with 3-cycle latency -> o_imem_req high and o_imem_addr stable for 3 cycles per fetch; one o_valid beat per fetch.
- i_stall held for 4 cycles during back-to-back fetch -> one word goes to the skid buffer, then req=0 (FULL); after stall release the output sequence is gap-free and in order with no lost or duplicated PC.
- i_redirect to 0x100 while a 3-cycle access to 0x8 is in flight -> DRAIN; the 0x8 data is never presented; next o_imem_addr=0x100; the first o_next_pc after the redirect is 0x104.
- i_redirect in the same cycle as i_stall=1 and o_valid=1 -> o_valid=0 next cycle; pc=target.
- FETCH_HALT_EN defined, memory returns 0xFFFFFFFF at 0xC -> that word presented with o_valid=1; o_halted=1; no req until a redirect to 0x0 clears o_halted and fetch resumes at 0x0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the instruction-fetch sequencer: state encoding,
// default reset PC / step / halt encoding and the datapath width.
package fetch_ctrl_pkg;

    localparam int XLEN = 32;

    typedef logic [2:0] fetch_state_t;

    localparam logic [2:0] ST_BOOT  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_FULL  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    localparam logic [XLEN-1:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEF_PC_STEP    = 32'd4;
    localparam logic [XLEN-1:0] DEF_HALT_INSTR = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched word (instr + next PC) that
// arrived while the IF/ID slot was stalled. Clear wins over read and write.
module fetch_skid_buf
    import fetch_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            wr,
    input  logic            rd,
    input  logic            clr,
    input  logic [XLEN-1:0] wr_instr,
    input  logic [XLEN-1:0] wr_next_pc,
    output logic            full,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] next_pc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full    <= 1'b0;
            instr   <= '0;
            next_pc <= '0;
        end else if (clr || rd) begin
            full <= 1'b0;
        end else if (wr) begin
            full    <= 1'b1;
            instr   <= wr_instr;
            next_pc <= wr_next_pc;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, handshakes with a variable-latency
// memory and feeds IF/ID. Optional halt-on-HALT_INSTR support: `define FETCH_HALT_EN.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [XLEN-1:0] PC_STEP    = DEF_PC_STEP,
    parameter logic [XLEN-1:0] HALT_INSTR = DEF_HALT_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ready,
    input  logic [XLEN-1:0] i_imem_instr,
    input  logic            i_stall,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_valid,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_halted
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] drain_addr;
    logic [XLEN-1:0] pc_inc;
    logic            consumed;
    logic            slot_free;
    logic            redirect_take;
    logic            halt_hit;
    logic            skid_halt;
    logic            skid_wr;
    logic            skid_rd;
    logic            skid_full;
    logic [XLEN-1:0] skid_instr;
    logic [XLEN-1:0] skid_next_pc;

    assign consumed      = o_valid && !i_stall;
    assign slot_free     = !o_valid || !i_stall;
    assign redirect_take = i_redirect && (state != ST_BOOT);
    assign pc_inc        = pc + PC_STEP;

    assign skid_wr = (state == ST_FETCH) && i_imem_ready && !slot_free && !redirect_take;
    assign skid_rd = (state == ST_FULL) && consumed && !redirect_take;

    // DRAIN keeps presenting the abandoned address until memory answers.
    assign o_imem_req  = (state == ST_FETCH) || (state == ST_DRAIN);
    assign o_imem_addr = (state == ST_DRAIN) ? drain_addr : pc;

`ifdef FETCH_HALT_EN
    assign halt_hit  = (i_imem_instr == HALT_INSTR);
    assign skid_halt = (skid_instr == HALT_INSTR);
    assign o_halted  = (state == ST_HALT);
`else
    logic unused_halt_instr;
    assign unused_halt_instr = ^HALT_INSTR;
    assign halt_hit  = 1'b0;
    assign skid_halt = 1'b0;
    assign o_halted  = 1'b0;
`endif

    fetch_skid_buf u_skid (
        .clk        (clk),
        .reset      (reset),
        .wr         (skid_wr),
        .rd         (skid_rd),
        .clr        (redirect_take),
        .wr_instr   (i_imem_instr),
        .wr_next_pc (pc_inc),
        .full       (skid_full),
        .instr      (skid_instr),
        .next_pc    (skid_next_pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_BOOT;
            pc         <= RESET_PC;
            drain_addr <= '0;
            o_valid    <= 1'b0;
            o_instr    <= '0;
            o_next_pc  <= '0;
        end else if (redirect_take) begin
            // A ready in this cycle is dropped; only an unanswered access must drain.
            o_valid <= 1'b0;
            pc      <= i_redirect_pc;
            if (o_imem_req && !i_imem_ready) begin
                state      <= ST_DRAIN;
                drain_addr <= o_imem_addr;
            end else begin
                state <= ST_FETCH;
            end
        end else begin
            if (consumed) begin
                o_valid <= 1'b0;
            end
            case (state)
                ST_BOOT: state <= ST_FETCH;
                ST_FETCH: begin
                    if (i_imem_ready) begin
                        pc <= pc_inc;
                        if (slot_free) begin
                            o_valid   <= 1'b1;
                            o_instr   <= i_imem_instr;
                            o_next_pc <= pc_inc;
                            state     <= halt_hit ? ST_HALT : ST_FETCH;
                        end else begin
                            state <= ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (consumed) begin
                        o_valid   <= skid_full;
                        o_instr   <= skid_instr;
                        o_next_pc <= skid_next_pc;
                        state     <= skid_halt ? ST_HALT : ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (i_imem_ready) begin
                        state <= ST_FETCH;
                    end
                end
`ifdef FETCH_HALT_EN
                ST_HALT: state <= ST_HALT;
`endif
                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a latency-configurable memory responder plus an
// in-order PC stream model that predicts every word IF/ID should accept.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ready = 1'b0;
    logic [31:0] i_imem_instr = 32'h0;
    logic        i_stall = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_next_pc;
    logic        o_halted;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_pc = 32'h0;
    int          mem_lat = 1;
    bit          lat_rand = 1'b0;
    bit          halt_on = 1'b0;
    logic [31:0] halt_addr = 32'h0000_000C;

    fetch_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ready  (i_imem_ready),
        .i_imem_instr  (i_imem_instr),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .o_instr       (o_instr),
        .o_next_pc     (o_next_pc),
        .o_halted      (o_halted)
    );

    always #5 clk = ~clk;

    // Memory image: a scrambled function of the address, never all-ones
    // except at halt_addr when halt_on is set.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (halt_on && a == halt_addr) return 32'hFFFF_FFFF;
        return ((a * 32'h9E37_79B1) ^ 32'h1357_9BDF) & 32'h7FFF_FFFF;
    endfunction

    // Responder: ready on the N-th consecutive cycle a request is held.
    initial begin : responder
        int acc;
        int cur_lat;
        acc = 0;
        cur_lat = 1;
        forever begin
            @(negedge clk);
            if (reset && o_imem_req) begin
                if (acc == 0) cur_lat = lat_rand ? int'($urandom_range(1, 4)) : mem_lat;
                acc++;
                if (acc >= cur_lat) begin
                    i_imem_ready = 1'b1;
                    i_imem_instr = mem_word(o_imem_addr);
                    acc = 0;
                end else begin
                    i_imem_ready = 1'b0;
                    i_imem_instr = $urandom;
                end
            end else begin
                i_imem_ready = 1'b0;
                acc = 0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b0;
        i_stall = 1'b0;
        i_redirect = 1'b0;
        i_redirect_pc = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_pc = 32'h0;
        #1;
    endtask

    task automatic test_reset;
        bit seen;
        mem_lat = 3; lat_rand = 1'b0; halt_on = 1'b0;
        reset = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if ({o_imem_req, o_valid, o_halted} !== 3'b000 || o_instr !== 32'h0 || o_next_pc !== 32'h0) begin
            n_err++;
            $display("FAIL reset_values: req/valid/halted=%b instr=%h next_pc=%h, required 000/0/0",
                     {o_imem_req, o_valid, o_halted}, o_instr, o_next_pc);
        end
        do_reset();
        n_cmp++;
        if (o_imem_req !== 1'b0) begin
            n_err++; $display("FAIL boot_req: got %b, required 0", o_imem_req);
        end
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk); #1;
            seen = o_valid;
        end
        n_cmp++;
        if (!seen) begin
            n_err++; $display("FAIL reset_pre_valid: o_valid never rose, required 1 within 12 cycles");
        end
        // Drop reset between clock edges: outputs must clear without an edge.
        #2; reset = 1'b0; #1;
        n_cmp++;
        if ({o_imem_req, o_valid, o_halted} !== 3'b000 || o_instr !== 32'h0 || o_next_pc !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: req/valid/halted=%b instr=%h next_pc=%h, required 000/0/0",
                     {o_imem_req, o_valid, o_halted}, o_instr, o_next_pc);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_pc = 32'h0;
        #1;
        n_cmp++;
        if (o_imem_req !== 1'b0) begin
            n_err++; $display("FAIL reboot_req: got %b, required 0", o_imem_req);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0 || o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reboot_fetch: req=%b addr=%h valid=%b, required 1/00000000/0",
                     o_imem_req, o_imem_addr, o_valid);
        end
    endtask

    task automatic test_zero_wait;
        mem_lat = 1; lat_rand = 1'b0; halt_on = 1'b0;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (o_imem_req !== 1'b1 || o_imem_addr !== 32'(4 * k)) begin
                n_err++;
                $display("FAIL zw_addr[%0d]: req=%b addr=%h, required 1/%h", k, o_imem_req, o_imem_addr, 32'(4 * k));
            end
            n_cmp++;
            if (k == 0) begin
                if (o_valid !== 1'b0) begin
                    n_err++; $display("FAIL zw_first_valid: got %b, required 0", o_valid);
                end
            end else if (o_valid !== 1'b1 || o_instr !== mem_word(32'(4 * (k - 1))) || o_next_pc !== 32'(4 * k)) begin
                n_err++;
                $display("FAIL zw_out[%0d]: valid=%b instr=%h next_pc=%h, required 1/%h/%h",
                         k, o_valid, o_instr, o_next_pc, mem_word(32'(4 * (k - 1))), 32'(4 * k));
            end
        end
    endtask

    task automatic test_latency;
        logic [31:0] cur;
        int run;
        int beats;
        bit prev_valid;
        mem_lat = 3; lat_rand = 1'b0; halt_on = 1'b0;
        do_reset();
        cur = 32'hFFFF_FFFF; run = 0; beats = 0; prev_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (o_imem_req) begin
                if (o_imem_addr === cur) run++;
                else begin
                    if (cur !== 32'hFFFF_FFFF) begin
                        n_cmp++;
                        if (run !== 3) begin
                            n_err++; $display("FAIL lat_hold @%h: held %0d cycles, required 3", cur, run);
                        end
                    end
                    cur = o_imem_addr; run = 1;
                end
            end
            if (o_valid) begin
                beats++;
                n_cmp++;
                if (prev_valid) begin
                    n_err++; $display("FAIL lat_beat: valid high 2 cycles in a row, required single beat");
                end
            end
            if (o_valid && !i_stall) begin
                n_cmp++;
                if (o_instr !== mem_word(exp_pc) || o_next_pc !== exp_pc + 32'd4) begin
                    n_err++;
                    $display("FAIL lat_stream: instr=%h next_pc=%h, required %h/%h",
                             o_instr, o_next_pc, mem_word(exp_pc), exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
            end
            prev_valid = o_valid;
        end
        n_cmp++;
        if (beats !== 13) begin
            n_err++; $display("FAIL lat_beats: got %0d beats, required 13", beats);
        end
    endtask

    task automatic test_stall;
        logic [31:0] held;
        mem_lat = 1; lat_rand = 1'b0; halt_on = 1'b0;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (o_valid && !i_stall) begin
                n_cmp++;
                if (o_instr !== mem_word(exp_pc) || o_next_pc !== exp_pc + 32'd4) begin
                    n_err++;
                    $display("FAIL stall_pre: instr=%h next_pc=%h, required %h/%h",
                             o_instr, o_next_pc, mem_word(exp_pc), exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
            end
        end
        held = 32'h0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            i_stall = 1'b1;
            #1;
            n_cmp++;
            if (j == 0) begin
                held = o_instr;
                if (o_imem_req !== 1'b1 || o_valid !== 1'b1) begin
                    n_err++; $display("FAIL stall_first: req=%b valid=%b, required 1/1", o_imem_req, o_valid);
                end
            end else if (o_imem_req !== 1'b0 || o_valid !== 1'b1 || o_instr !== held) begin
                n_err++;
                $display("FAIL stall_full[%0d]: req=%b valid=%b instr=%h, required 0/1/%h",
                         j, o_imem_req, o_valid, o_instr, held);
            end
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            i_stall = 1'b0;
            #1;
            n_cmp++;
            if (o_valid !== 1'b1 || o_instr !== mem_word(exp_pc) || o_next_pc !== exp_pc + 32'd4) begin
                n_err++;
                $display("FAIL stall_release[%0d]: valid=%b instr=%h next_pc=%h, required 1/%h/%h",
                         c, o_valid, o_instr, o_next_pc, mem_word(exp_pc), exp_pc + 32'd4);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_redirect_drain;
        bit found;
        bit got;
        mem_lat = 3; lat_rand = 1'b0; halt_on = 1'b0;
        do_reset();
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk); #1;
            if (o_valid && !i_stall) exp_pc = exp_pc + 32'd4;
            found = o_imem_req && (o_imem_addr == 32'h8);
        end
        n_cmp++;
        if (!found) begin
            n_err++; $display("FAIL drain_setup: access to 00000008 not seen within 20 cycles");
        end
        @(negedge clk);
        i_redirect = 1'b1;
        i_redirect_pc = 32'h100;
        #1;
        exp_pc = 32'h100;
        @(negedge clk);
        i_redirect = 1'b0;
        #1;
        n_cmp++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h8 || o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain_hold: req=%b addr=%h valid=%b, required 1/00000008/0", o_imem_req, o_imem_addr, o_valid);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h100 || o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain_refetch: req=%b addr=%h valid=%b, required 1/00000100/0", o_imem_req, o_imem_addr, o_valid);
        end
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk); #1;
            if (o_valid) begin
                got = 1'b1;
                n_cmp++;
                if (o_instr !== mem_word(exp_pc) || o_next_pc !== 32'h104) begin
                    n_err++;
                    $display("FAIL drain_first: instr=%h next_pc=%h, required %h/00000104",
                             o_instr, o_next_pc, mem_word(exp_pc));
                end
            end
        end
        n_cmp++;
        if (!got) begin
            n_err++; $display("FAIL drain_timeout: no valid within 10 cycles after redirect");
        end
    endtask

    task automatic test_redirect_stall;
        mem_lat = 1; lat_rand = 1'b0; halt_on = 1'b0;
        do_reset();
        repeat (3) @(negedge clk);
        i_stall = 1'b1;
        @(negedge clk);
        i_redirect = 1'b1;
        i_redirect_pc = 32'h40;
        #1;
        n_cmp++;
        if (o_valid !== 1'b1) begin
            n_err++; $display("FAIL rs_pre_valid: got %b, required 1", o_valid);
        end
        @(negedge clk);
        i_stall = 1'b0;
        i_redirect = 1'b0;
        #1;
        n_cmp++;
        if (o_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h40) begin
            n_err++;
            $display("FAIL rs_flush: valid=%b req=%b addr=%h, required 0/1/00000040", o_valid, o_imem_req, o_imem_addr);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (o_valid !== 1'b1 || o_instr !== mem_word(32'h40) || o_next_pc !== 32'h44) begin
            n_err++;
            $display("FAIL rs_resume: valid=%b instr=%h next_pc=%h, required 1/%h/00000044",
                     o_valid, o_instr, o_next_pc, mem_word(32'h40));
        end
    endtask

    task automatic test_halt_word;
        mem_lat = 1; lat_rand = 1'b0; halt_on = 1'b1;
        do_reset();
        repeat (5) @(negedge clk);
        #1;
        n_cmp++;
        if (o_valid !== 1'b1 || o_instr !== 32'hFFFF_FFFF || o_next_pc !== 32'h10) begin
            n_err++;
            $display("FAIL halt_word: valid=%b instr=%h next_pc=%h, required 1/ffffffff/00000010",
                     o_valid, o_instr, o_next_pc);
        end
`ifdef FETCH_HALT_EN
        for (int j = 0; j < 4; j++) begin
            if (j > 0) begin
                @(negedge clk); #1;
            end
            n_cmp++;
            if (o_halted !== 1'b1 || o_imem_req !== 1'b0) begin
                n_err++; $display("FAIL halt_hold[%0d]: halted=%b req=%b, required 1/0", j, o_halted, o_imem_req);
            end
        end
        @(negedge clk);
        i_redirect = 1'b1;
        i_redirect_pc = 32'h0;
        @(negedge clk);
        i_redirect = 1'b0;
        #1;
        n_cmp++;
        if (o_halted !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL halt_exit: halted=%b req=%b addr=%h, required 0/1/00000000", o_halted, o_imem_req, o_imem_addr);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (o_valid !== 1'b1 || o_instr !== mem_word(32'h0) || o_next_pc !== 32'h4) begin
            n_err++;
            $display("FAIL halt_resume: valid=%b instr=%h next_pc=%h, required 1/%h/00000004",
                     o_valid, o_instr, o_next_pc, mem_word(32'h0));
        end
`else
        n_cmp++;
        if (o_halted !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h10) begin
            n_err++;
            $display("FAIL halt_plain: halted=%b req=%b addr=%h, required 0/1/00000010", o_halted, o_imem_req, o_imem_addr);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (o_valid !== 1'b1 || o_instr !== mem_word(32'h10) || o_next_pc !== 32'h14) begin
            n_err++;
            $display("FAIL halt_plain_next: valid=%b instr=%h next_pc=%h, required 1/%h/00000014",
                     o_valid, o_instr, o_next_pc, mem_word(32'h10));
        end
`endif
        halt_on = 1'b0;
    endtask

    task automatic test_random;
        bit          prev_wait;
        bit          prev_hold;
        logic [31:0] prev_addr;
        logic [31:0] held_i;
        logic [31:0] held_n;
        lat_rand = 1'b1; halt_on = 1'b0;
        do_reset();
        prev_wait = 1'b0; prev_hold = 1'b0;
        prev_addr = 32'h0; held_i = 32'h0; held_n = 32'h0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            i_stall = ($urandom_range(0, 9) < 3);
            i_redirect = (c > 2) && ($urandom_range(0, 24) == 0);
            i_redirect_pc = $urandom_range(0, 255) << 2;
            #1;
            if (prev_wait) begin
                n_cmp++;
                if (o_imem_req !== 1'b1 || o_imem_addr !== prev_addr) begin
                    n_err++;
                    $display("FAIL rnd_addr_stable[%0d]: req=%b addr=%h, required 1/%h", c, o_imem_req, o_imem_addr, prev_addr);
                end
            end
            if (prev_hold) begin
                n_cmp++;
                if (o_valid !== 1'b1 || o_instr !== held_i || o_next_pc !== held_n) begin
                    n_err++;
                    $display("FAIL rnd_hold[%0d]: valid=%b instr=%h next_pc=%h, required 1/%h/%h",
                             c, o_valid, o_instr, o_next_pc, held_i, held_n);
                end
            end
            n_cmp++;
            if (o_halted !== 1'b0) begin
                n_err++; $display("FAIL rnd_halted[%0d]: got %b, required 0", c, o_halted);
            end
            if (o_valid && !i_stall) begin
                n_cmp++;
                if (o_instr !== mem_word(exp_pc) || o_next_pc !== exp_pc + 32'd4) begin
                    n_err++;
                    $display("FAIL rnd_stream[%0d]: instr=%h next_pc=%h, required %h/%h",
                             c, o_instr, o_next_pc, mem_word(exp_pc), exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
            end
            if (i_redirect) exp_pc = i_redirect_pc;
            prev_wait = o_imem_req && !i_imem_ready && !i_redirect;
            prev_wait = prev_wait || (o_imem_req && !i_imem_ready && i_redirect);
            prev_addr = o_imem_addr;
            prev_hold = o_valid && i_stall && !i_redirect;
            held_i = o_instr;
            held_n = o_next_pc;
        end
        @(negedge clk);
        i_stall = 1'b0;
        i_redirect = 1'b0;
        lat_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall();
        test_redirect_drain();
        test_redirect_stall();
        test_halt_word();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
